out_seq_ctrl: RTL and testbench

OUT_SEQ_CTRL -- requirements
Module: out_seq_ctrl

---
 rtl/out_seq_ctrl_if.sv | 41 ++++
 rtl/out_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_out_seq_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/out_seq_ctrl_if.sv
// ============================================================================
// Module      : out_seq_ctrl_if
// Description : Handshake/status bundle between the decoder output sequencer
//               and its datapath / downstream byte sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface out_seq_ctrl_if #(
    parameter int CW = 11
);
    logic          finish_nms;
    logic          out_ready;
    logic          ovf_clr;
    logic          load_vout;
    logic          shift_out;
    logic          en_out;
    logic          rst_flag;
    logic          d_valid;
    logic          sof;
    logic          eof;
    logic          busy;
    logic          frame_done;
    logic          ovf_err;
    logic [CW-1:0] byte_cnt;

    // master: the sequencer itself; slave: the environment around it
    modport master (
        input  finish_nms, out_ready, ovf_clr,
        output load_vout, shift_out, en_out, rst_flag, d_valid, sof, eof,
               busy, frame_done, ovf_err, byte_cnt
    );

    modport slave (
        output finish_nms, out_ready, ovf_clr,
        input  load_vout, shift_out, en_out, rst_flag, d_valid, sof, eof,
               busy, frame_done, ovf_err, byte_cnt
    );
endinterface

`default_nettype wire

// File: rtl/out_seq_ctrl.sv
// ============================================================================
// Module      : out_seq_ctrl
// Description : Sequences a decoded codeword out of the datapath shift register
//               as NBYTES bytes with valid/ready handshake and frame markers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_seq_ctrl #(
    parameter int NBYTES = 1152,
    parameter int CW     = 11
) (
    input  wire            clk,
    input  wire            rst,
    out_seq_ctrl_if.master bus
);

    if ((1 << CW) <= NBYTES) begin : g_bad_cw
        $error("out_seq_ctrl: CW too small for NBYTES");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_last_idx = CW'(NBYTES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_byte_cnt;
    logic          r_ovf_err;

    logic w_load_vout;
    logic w_shift_out;
    logic w_en_out;
    logic w_rst_flag;
    logic w_d_valid;
    logic w_frame_done;
    logic w_accept;
    logic w_last;

    assign w_accept = (r_state == SEND) && bus.out_ready && !rst;
    assign w_last   = (r_byte_cnt == c_last_idx);

    // Outputs are forced to their idle values while rst is high, even before
    // the synchronous reset has taken effect on the state register.
    always_comb begin
        w_next       = r_state;
        w_load_vout  = 1'b0;
        w_shift_out  = 1'b0;
        w_en_out     = 1'b0;
        w_rst_flag   = 1'b1;
        w_d_valid    = 1'b0;
        w_frame_done = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.finish_nms) w_next = LOAD;
                end
                LOAD: begin
                    w_load_vout = 1'b1;
                    w_next      = SEND;
                end
                SEND: begin
                    w_d_valid = 1'b1;
                    if (bus.out_ready) begin
                        w_shift_out = 1'b1;
                        w_en_out    = 1'b1;
                        if (w_last) w_next = DONE;
                    end
                end
                DONE: begin
                    w_frame_done = 1'b1;
                    w_rst_flag   = 1'b0;
                    w_next       = bus.finish_nms ? LOAD : IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == LOAD) begin
                r_byte_cnt <= '0;
            end else if (w_accept) begin
                r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
            end
        end
    end

    // A new codeword while one is still being emitted is dropped; flag it.
    // The set condition takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (bus.finish_nms && (r_state == LOAD || r_state == SEND)) begin
            r_ovf_err <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf_err <= 1'b0;
        end
    end

    assign bus.load_vout  = w_load_vout;
    assign bus.shift_out  = w_shift_out;
    assign bus.en_out     = w_en_out;
    assign bus.rst_flag   = w_rst_flag;
    assign bus.d_valid    = w_d_valid;
    assign bus.sof        = w_d_valid && (r_byte_cnt == '0);
    assign bus.eof        = w_d_valid && w_last;
    assign bus.busy       = !rst && (r_state != IDLE);
    assign bus.frame_done = w_frame_done;
    assign bus.ovf_err    = r_ovf_err;
    assign bus.byte_cnt   = r_byte_cnt;

endmodule

`default_nettype wire

// File: tb/tb_out_seq_ctrl.sv
// ============================================================================
// Module      : tb_out_seq_ctrl
// Description : Scoreboard bench for out_seq_ctrl: stimulus queues expected
//               bytes/loads/frame ends, a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_seq_ctrl;

    localparam int NBYTES = 1152;
    localparam int CW     = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   frame_acc = 0;
    logic toggle = 1'b0;

    int byte_q[$];
    int load_q[$];
    int done_q[$];

    out_seq_ctrl_if #(.CW(CW)) bus ();

    out_seq_ctrl #(.NBYTES(NBYTES), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: unexpected event, got 1, expected 0 (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        check("shift_gate", bus.shift_out, bus.d_valid && bus.out_ready);
        check("en_eq_shift", bus.en_out, bus.shift_out);
        check("load_excl", bus.load_vout && bus.shift_out, 0);
        check("rst_flag", bus.rst_flag, !bus.frame_done);
        if (bus.load_vout) begin
            frame_acc = 0;
            if (load_q.size() == 0) fail_now("load_extra");
            else check("load_cycle", cyc, load_q.pop_front());
        end
        if (bus.d_valid && bus.out_ready) begin
            frame_acc++;
            if (byte_q.size() == 0) begin
                fail_now("byte_extra");
            end else begin
                int e;
                e = byte_q.pop_front();
                check("byte_cnt", bus.byte_cnt, e);
                check("sof", bus.sof, e == 0);
                check("eof", bus.eof, e == NBYTES - 1);
            end
        end
        if (bus.frame_done) begin
            check("frame_bytes", frame_acc, NBYTES);
            if (done_q.size() == 0) begin
                fail_now("done_extra");
            end else begin
                int e;
                e = done_q.pop_front();
                if (e >= 0) check("done_cycle", cyc, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.finish_nms = 1'b0;
        bus.ovf_clr    = 1'b0;
        bus.out_ready  = toggle ? ~bus.out_ready : 1'b1;
    endtask

    task automatic push_frame(input int c, input int nbytes, input bit timed_done);
        load_q.push_back(c + 1);
        for (int i = 0; i < nbytes; i++) byte_q.push_back(i);
        if (nbytes == NBYTES) done_q.push_back(timed_done ? c + NBYTES + 2 : -1);
    endtask

    task automatic wait_idle(output int end_cyc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy && n < 5000);
        check("idle_reached", bus.busy, 0);
        end_cyc = cyc;
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (bus.byte_cnt != CW'(target) && n < 3000) begin
            tick();
            n++;
        end
        check("reach_cnt", bus.byte_cnt, target);
    endtask

    initial begin
        int c;
        int e;
        bus.finish_nms = 1'b1;
        bus.ovf_clr    = 1'b0;
        bus.out_ready  = 1'b1;

        // reset values, with a coincident finish_nms that must be dropped
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_dvalid", bus.d_valid, 0);
        check("rst_flag_hi", bus.rst_flag, 1);
        check("rst_cnt", bus.byte_cnt, 0);
        check("rst_ovf", bus.ovf_err, 0);
        check("rst_done", bus.frame_done, 0);
        tick();
        check("rst_finish_dropped", bus.busy, 0);
        check("rst_no_load", bus.load_vout, 0);

        // nominal frame
        tick();
        bus.finish_nms = 1'b1;
        c = cyc;
        push_frame(c, NBYTES, 1'b1);
        wait_idle(e);
        check("nominal_latency", e - c, NBYTES + 3);
        check("nominal_ovf", bus.ovf_err, 0);

        // backpressure: out_ready alternates every cycle
        toggle = 1'b1;
        tick();
        bus.finish_nms = 1'b1;
        push_frame(cyc, NBYTES, 1'b0);
        wait_idle(e);
        toggle = 1'b0;

        // overflow, clear, and simultaneous set/clear
        tick();
        bus.finish_nms = 1'b1;
        push_frame(cyc, NBYTES, 1'b1);
        wait_cnt(500);
        bus.finish_nms = 1'b1;
        tick();
        check("ovf_set", bus.ovf_err, 1);
        wait_cnt(700);
        bus.ovf_clr = 1'b1;
        tick();
        check("ovf_clr_mid", bus.ovf_err, 0);
        wait_cnt(900);
        bus.finish_nms = 1'b1;
        bus.ovf_clr    = 1'b1;
        tick();
        check("ovf_set_wins", bus.ovf_err, 1);
        wait_idle(e);
        check("ovf_sticky", bus.ovf_err, 1);
        bus.ovf_clr = 1'b1;
        tick();
        check("ovf_cleared", bus.ovf_err, 0);

        // back-to-back: second finish_nms in DONE
        bus.finish_nms = 1'b1;
        push_frame(cyc, NBYTES, 1'b1);
        c = 0;
        while (!bus.frame_done && c < 3000) begin
            tick();
            c++;
        end
        check("b2b_done_seen", bus.frame_done, 1);
        bus.finish_nms = 1'b1;
        push_frame(cyc, NBYTES, 1'b1);
        tick();
        check("b2b_load", bus.load_vout, 1);
        check("b2b_ovf", bus.ovf_err, 0);
        wait_idle(e);
        check("b2b_ovf_end", bus.ovf_err, 0);

        // mid-frame reset at byte 700, then a clean frame
        tick();
        bus.finish_nms = 1'b1;
        push_frame(cyc, 700, 1'b0);
        wait_cnt(700);
        rst = 1'b1;
        tick();
        check("mrst_busy", bus.busy, 0);
        check("mrst_dvalid", bus.d_valid, 0);
        check("mrst_cnt", bus.byte_cnt, 0);
        check("mrst_flag", bus.rst_flag, 1);
        bus.finish_nms = 1'b1;
        c = cyc;
        push_frame(c, NBYTES, 1'b1);
        wait_idle(e);
        check("mrst_latency", e - c, NBYTES + 3);

        repeat (3) tick();
        check("byte_q_empty", byte_q.size(), 0);
        check("load_q_empty", load_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
